// File: rtl/tlv_pkg.sv
// Shared constants and state encoding for the TLV seed loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tlv_pkg;

   localparam int BYTE_W     = 8;
   localparam int WORD_W     = 32;
   localparam int LANE_W     = $clog2(WORD_W / BYTE_W);
   localparam int SEED_WORDS = 16;
   localparam int SEED_BYTES = 4 * SEED_WORDS;
   localparam int IDX_W      = $clog2(SEED_WORDS);
   localparam int CNT_W      = $clog2(SEED_BYTES + 1);

   localparam logic [BYTE_W-1:0] TYPE_SEED = 8'h01;
   localparam logic [BYTE_W-1:0] TYPE_GO   = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN    = 3'd1,
      ST_VALUE  = 3'd2,
      ST_SKIP   = 3'd3,
      ST_STREAM = 3'd4
   } state_t;

endpackage

// File: rtl/seed_word_buffer.sv
// Seed register file: SEED_WORDS x 32 with byte-lane writes and a registered read.
// Latency: write visible next cycle; read data valid one cycle after i_re.
// Backpressure: none; writes and reads are always accepted.
// Ports: i_clk/i_rst clock and sync reset (read register only); i_we/i_waddr/
//        i_lane/i_wbyte byte write; i_re/i_raddr read request; o_rdata word.
module seed_word_buffer
   import tlv_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [LANE_W-1:0] i_lane,
   input  logic [BYTE_W-1:0] i_wbyte,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic [WORD_W-1:0] o_rdata
);

   // Contents are don't-care after reset, so the array itself is not reset.
   logic [WORD_W-1:0] r_mem [SEED_WORDS];
   logic [WORD_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr][BYTE_W*i_lane +: BYTE_W] <= i_wbyte;
      end
   end

   // Read register only updates on request so the output holds a defined value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/tlv_seed_loader.sv
// TLV byte-stream parser: builds a 512-bit seed from SEED frames, streams it on GO.
// Latency: GO value byte accepted in cycle N -> seed words in cycles N+1..N+16.
// Backpressure: none; bytes arriving while streaming are dropped and flagged.
// Ports: i_clk, i_rst (sync, active-high); i_rx_valid/i_rx_data byte strobe;
//        o_seed_valid/o_seed word stream; o_busy streaming; o_seed_loaded all
//        seed bytes present; o_frame_err error pulse; o_err_sticky latched error.
// Optional: define TLV_TIMEOUT_EN for an inter-byte timeout inside frames.
module tlv_seed_loader
   import tlv_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_rx_valid,
   input  logic [BYTE_W-1:0] i_rx_data,
   output logic              o_seed_valid,
   output logic [WORD_W-1:0] o_seed,
   output logic              o_busy,
   output logic              o_seed_loaded,
   output logic              o_frame_err,
   output logic              o_err_sticky
);

   state_t            r_state, w_next;
   logic [BYTE_W-1:0] r_type;
   logic [BYTE_W-1:0] r_len;
   logic [CNT_W-1:0]  r_byte_cnt;
   logic [IDX_W-1:0]  r_word_idx;
   logic              r_seed_valid;
   logic              r_frame_err;
   logic              r_err_sticky;

   logic w_err, w_type_ld, w_len_ld, w_len_dec, w_we, w_start, w_end, w_re;
   logic w_loaded, w_last, w_in_frame, w_timeout;

   assign w_loaded   = (r_byte_cnt == CNT_W'(SEED_BYTES));
   assign w_last     = (r_len == 8'd1);
   assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_VALUE) || (r_state == ST_SKIP);

`ifdef TLV_TIMEOUT_EN
   localparam int TIMEOUT_CYCLES = 1_000_000;
   localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] r_to_cnt;

   // Counts idle cycles inside a frame; any received byte restarts it.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_rx_valid || !w_in_frame) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end
   assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_err     = 1'b0;
      w_type_ld = 1'b0;
      w_len_ld  = 1'b0;
      w_len_dec = 1'b0;
      w_we      = 1'b0;
      w_start   = 1'b0;
      w_end     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // 8'h00 in IDLE is line fill, not a type byte.
            if (i_rx_valid && (i_rx_data != '0)) begin
               w_type_ld = 1'b1;
               w_next    = ST_LEN;
            end
         end
         ST_LEN: begin
            if (i_rx_valid) begin
               w_len_ld = 1'b1;
               if (i_rx_data == '0) begin
                  w_err  = 1'b1;
                  w_next = ST_IDLE;
               end else if ((r_type == TYPE_SEED) ||
                            ((r_type == TYPE_GO) && (i_rx_data == 8'd1))) begin
                  w_next = ST_VALUE;
               end else begin
                  w_err  = 1'b1;
                  w_next = ST_SKIP;
               end
            end
         end
         ST_VALUE: begin
            if (i_rx_valid) begin
               w_len_dec = 1'b1;
               if (r_type == TYPE_GO) begin
                  if (w_loaded) begin
                     w_start = 1'b1;
                     w_next  = ST_STREAM;
                  end else begin
                     w_err  = 1'b1;
                     w_next = ST_IDLE;
                  end
               end else if (w_loaded) begin
                  // Seed already full: drop this byte and skip the rest of the frame.
                  w_err  = 1'b1;
                  w_next = w_last ? ST_IDLE : ST_SKIP;
               end else begin
                  w_we = 1'b1;
                  if (w_last) begin
                     w_next = ST_IDLE;
                  end
               end
            end
         end
         ST_SKIP: begin
            if (i_rx_valid) begin
               w_len_dec = 1'b1;
               if (w_last) begin
                  w_next = ST_IDLE;
               end
            end
         end
         ST_STREAM: begin
            if (i_rx_valid) begin
               w_err = 1'b1;
            end
            // word_idx wraps to 0 once the last word has been requested.
            if (r_word_idx == '0) begin
               w_end  = 1'b1;
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
      if (w_timeout && w_in_frame && !i_rx_valid) begin
         w_err  = 1'b1;
         w_next = ST_IDLE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_type       <= '0;
         r_len        <= '0;
         r_byte_cnt   <= '0;
         r_word_idx   <= '0;
         r_seed_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_err_sticky <= 1'b0;
      end else begin
         if (w_type_ld) begin
            r_type <= i_rx_data;
         end
         if (w_len_ld) begin
            r_len <= i_rx_data;
         end else if (w_len_dec) begin
            r_len <= r_len - 1'b1;
         end
         if (w_end) begin
            r_byte_cnt <= '0;
         end else if (w_we) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
         end
         if (w_end) begin
            r_word_idx <= '0;
         end else if (w_start || (r_state == ST_STREAM)) begin
            r_word_idx <= r_word_idx + 1'b1;
         end
         r_seed_valid <= (w_next == ST_STREAM);
         r_frame_err  <= w_err;
         if (w_err) begin
            r_err_sticky <= 1'b1;
         end
      end
   end

   // Word 0 is read on the GO byte so it appears together with seed_valid.
   assign w_re = w_start || ((r_state == ST_STREAM) && !w_end);

   seed_word_buffer u_buf (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_we),
      .i_waddr (r_byte_cnt[IDX_W+LANE_W-1:LANE_W]),
      .i_lane  (r_byte_cnt[LANE_W-1:0]),
      .i_wbyte (i_rx_data),
      .i_re    (w_re),
      .i_raddr (r_word_idx),
      .o_rdata (o_seed)
   );

   assign o_seed_valid  = r_seed_valid;
   assign o_busy        = (r_state == ST_STREAM);
   assign o_seed_loaded = w_loaded;
   assign o_frame_err   = r_frame_err;
   assign o_err_sticky  = r_err_sticky;

endmodule
